pc_fetch_sequencer: RTL and testbench

//  Owns the architectural PC register and sequences instruction fetch for the

---
 rtl/pc_fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the architectural PC and sequences instruction fetch for the MIPS
//   datapath. Each instruction is requested from imem over a req/ack
//   handshake, held for decode until the datapath retires it, and then the
//   next PC is chosen: exception return, jump, taken branch or sequential.
//   An interrupt can be taken at retire; it saves the next PC in epc and
//   redirects fetch to IRQ_VEC. A fetch that waits too long for imem_ack
//   parks the block in a sticky fault state until reset.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   imem_req/addr         fetch request and word address (= pc)
//   imem_ack/rdata        fetch completion and instruction word
//   ins, ins_valid        latched instruction and its valid flag for decode
//   pc, pcp4              address of ins and that address plus 4
//   resolve, stall        retire request and hazard hold from the datapath
//   branch, zero, jump    control-flow qualifiers for the retiring ins
//   imm, jTarget, eret    branch offset (words), jump field, exception return
//   INT, intr_ack         level interrupt request and entry pulse
//   epc                   saved return PC
//   fault                 sticky imem timeout indication

module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] IRQ_VEC  = 32'h0000_0080,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ins,
   output logic        ins_valid,
   output logic [31:0] pc,
   output logic [31:0] pcp4,
   input  logic        resolve,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   input  logic [31:0] imm,
   input  logic [25:0] jTarget,
   input  logic        eret,
   input  logic        INT,
   output logic        intr_ack,
   output logic [31:0] epc,
   output logic        fault
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StIssue,
      StIrq,
      StFault
   } state_e;

   state_e          state;
   logic [CntW-1:0] wait_cnt;
   logic            ie;
   logic [31:0]     npc;
   logic            retire;
   logic            take_irq;

   // Offset bits above 29 fall off the word shift; the add wraps mod 2^32.
   logic [1:0] unused_imm;
   assign unused_imm = imm[31:30];

   assign imem_addr = pc;
   assign pcp4      = pc + 32'd4;
   assign retire    = resolve && !stall;
   // A simultaneous eret re-enables interrupts but the entry waits for the
   // next retire, so the return always lands first.
   assign take_irq  = INT && ie && !eret;

   always_comb begin
      npc = pcp4;
      if (eret) begin
         npc = epc;
      end else if (jump) begin
         npc = {pcp4[31:28], jTarget, 2'b00};
      end else if (branch && zero) begin
         npc = pcp4 + {imm[29:0], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         pc        <= RESET_PC & AlignMask;
         ins       <= 32'h0;
         ins_valid <= 1'b0;
         imem_req  <= 1'b0;
         intr_ack  <= 1'b0;
         epc       <= 32'h0;
         fault     <= 1'b0;
         ie        <= 1'b1;
         wait_cnt  <= '0;
      end else begin
         case (state)
            StIdle: begin
               state    <= StFetch;
               imem_req <= 1'b1;
            end

            StFetch: begin
               if (imem_ack) begin
                  ins       <= imem_rdata;
                  ins_valid <= 1'b1;
                  imem_req  <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= StIssue;
               end else if (wait_cnt == CntLast) begin
                  // TIMEOUT request cycles have gone by without an ack.
                  imem_req <= 1'b0;
                  fault    <= 1'b1;
                  wait_cnt <= '0;
                  state    <= StFault;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            StIssue: begin
               if (retire) begin
                  ins_valid <= 1'b0;
                  pc        <= npc & AlignMask;
                  if (eret) begin
                     ie <= 1'b1;
                  end
                  if (take_irq) begin
                     epc      <= npc & AlignMask;
                     ie       <= 1'b0;
                     intr_ack <= 1'b1;
                     state    <= StIrq;
                  end else begin
                     imem_req <= 1'b1;
                     state    <= StFetch;
                  end
               end
            end

            StIrq: begin
               pc       <= IRQ_VEC & AlignMask;
               intr_ack <= 1'b0;
               imem_req <= 1'b1;
               state    <= StFetch;
            end

            StFault: begin
               imem_req  <= 1'b0;
               ins_valid <= 1'b0;
               fault     <= 1'b1;
            end

            default: begin
               state    <= StIdle;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

   localparam int unsigned Timeout = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ins;
   logic        ins_valid;
   logic [31:0] pc;
   logic [31:0] pcp4;
   logic        resolve;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] imm;
   logic [25:0] jtarget;
   logic        eret;
   logic        int_req;
   logic        intr_ack;
   logic [31:0] epc;
   logic        fault;

   int checks   = 0;
   int failures = 0;

   pc_fetch_sequencer #(
      .RESET_PC(32'h0000_0000),
      .IRQ_VEC (32'h0000_0080),
      .TIMEOUT (Timeout)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .ins       (ins),
      .ins_valid (ins_valid),
      .pc        (pc),
      .pcp4      (pcp4),
      .resolve   (resolve),
      .stall     (stall),
      .branch    (branch),
      .zero      (zero),
      .jump      (jump),
      .imm       (imm),
      .jTarget   (jtarget),
      .eret      (eret),
      .INT       (int_req),
      .intr_ack  (intr_ack),
      .epc       (epc),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      int          ack_dly;
      logic        br;
      logic        z;
      logic        j;
      logic        er;
      logic        irq;
      logic [31:0] imm;
      logic [25:0] jt;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
      logic        exp_ack;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(logic [31:0] rdata, int dly, logic br, logic z, logic j,
                               logic er, logic irq, logic [31:0] im, logic [25:0] jt,
                               logic [31:0] epc_, logic [31:0] enext, logic eack,
                               logic [31:0] eepc);
      vec_t v;
      v.rdata = rdata; v.ack_dly = dly; v.br = br; v.z = z; v.j = j; v.er = er;
      v.irq = irq; v.imm = im; v.jt = jt; v.exp_pc = epc_; v.exp_next = enext;
      v.exp_ack = eack; v.exp_epc = eepc;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic clear_ctrl();
      resolve = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
      eret = 1'b0; imm = 32'h0; jtarget = 26'h0; int_req = 1'b0;
   endtask

   // Bounded wait for a fetch request, sampled on falling edges.
   task automatic wait_req(string name);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_req_seen"}, {31'h0, imem_req}, 32'h1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      wait_req(tag);
      check({tag, "_addr"}, imem_addr, v.exp_pc);
      for (int k = 0; k < v.ack_dly; k++) begin
         @(negedge clk);
         check({tag, "_req_held"}, {31'h0, imem_req}, 32'h1);
      end
      imem_ack = 1'b1;
      imem_rdata = v.rdata;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check({tag, "_valid"}, {31'h0, ins_valid}, 32'h1);
      check({tag, "_ins"}, ins, v.rdata);
      check({tag, "_pc"}, pc, v.exp_pc);
      check({tag, "_pcp4"}, pcp4, v.exp_pc + 32'd4);
      resolve = 1'b1; branch = v.br; zero = v.z; jump = v.j; eret = v.er;
      int_req = v.irq; imm = v.imm; jtarget = v.jt;
      @(negedge clk);
      clear_ctrl();
      check({tag, "_valid_drop"}, {31'h0, ins_valid}, 32'h0);
      check({tag, "_intr_ack"}, {31'h0, intr_ack}, {31'h0, v.exp_ack});
      if (v.exp_ack) begin
         check({tag, "_epc"}, epc, v.exp_epc);
         @(negedge clk);
         check({tag, "_intr_pulse_end"}, {31'h0, intr_ack}, 32'h0);
      end
      wait_req({tag, "_next"});
      check({tag, "_next_addr"}, imem_addr, v.exp_next);
   endtask

   initial begin
      //              rdata          dly br z  j  er irq imm            jt
      //              exp_pc         exp_next       ack epc
      vecs[0]  = mk(32'h2408_0001, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,
                    32'h0000_0000, 32'h0000_0004, 0, 32'h0);
      vecs[1]  = mk(32'h2409_0002, 1, 0, 0, 0, 0, 0, 32'h0,         26'h0,
                    32'h0000_0004, 32'h0000_0008, 0, 32'h0);
      vecs[2]  = mk(32'h0800_0040, 0, 0, 0, 1, 0, 0, 32'h0,         26'h40,
                    32'h0000_0008, 32'h0000_0100, 0, 32'h0);
      vecs[3]  = mk(32'h1000_FFFF, 2, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 26'h0,
                    32'h0000_0100, 32'h0000_00F4, 0, 32'h0);
      vecs[4]  = mk(32'h0800_0040, 0, 0, 0, 1, 0, 0, 32'h0,         26'h40,
                    32'h0000_00F4, 32'h0000_0100, 0, 32'h0);
      vecs[5]  = mk(32'h1000_FFFF, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 26'h0,
                    32'h0000_0100, 32'h0000_0104, 0, 32'h0);
      vecs[6]  = mk(32'h1000_FFC2, 0, 1, 1, 0, 0, 0, 32'h03FF_FFC2, 26'h0,
                    32'h0000_0104, 32'h1000_0010, 0, 32'h0);
      vecs[7]  = mk(32'h0800_0040, 1, 0, 0, 1, 0, 0, 32'h0,         26'h40,
                    32'h1000_0010, 32'h1000_0100, 0, 32'h0);
      vecs[8]  = mk(32'h0800_0008, 0, 1, 1, 1, 0, 0, 32'h0000_0005, 26'h8,
                    32'h1000_0100, 32'h1000_0020, 0, 32'h0);
      vecs[9]  = mk(32'h1000_FFFF, 0, 1, 1, 0, 0, 0, 32'hFBFF_FFFF, 26'h0,
                    32'h1000_0020, 32'h0000_0020, 0, 32'h0);
      vecs[10] = mk(32'h0000_0020, 0, 0, 0, 0, 0, 1, 32'h0,         26'h0,
                    32'h0000_0020, 32'h0000_0080, 1, 32'h0000_0024);
      vecs[11] = mk(32'h0000_0021, 0, 0, 0, 0, 0, 1, 32'h0,         26'h0,
                    32'h0000_0080, 32'h0000_0084, 0, 32'h0);
      vecs[12] = mk(32'h4200_0018, 1, 0, 0, 0, 1, 1, 32'h0,         26'h0,
                    32'h0000_0084, 32'h0000_0024, 0, 32'h0);
      vecs[13] = mk(32'h0000_0022, 0, 0, 0, 0, 0, 1, 32'h0,         26'h0,
                    32'h0000_0024, 32'h0000_0080, 1, 32'h0000_0028);
      vecs[14] = mk(32'h4200_0018, 0, 0, 0, 0, 1, 0, 32'h0,         26'h0,
                    32'h0000_0080, 32'h0000_0028, 0, 32'h0);

      clear_ctrl();
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, ins_valid}, 32'h0);
      check("rst_ins", ins, 32'h0);
      check("rst_fault", {31'h0, fault}, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_intr_ack", {31'h0, intr_ack}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // Stall holds the instruction even with resolve high; a stray ack
      // outside FETCH must not disturb ins.
      wait_req("stall");
      check("stall_addr", imem_addr, 32'h0000_0028);
      imem_ack = 1'b1;
      imem_rdata = 32'hA5A5_0000;
      @(negedge clk);
      stall = 1'b1;
      resolve = 1'b1;
      imem_rdata = 32'h1234_5678;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_valid", {31'h0, ins_valid}, 32'h1);
         check("stall_req", {31'h0, imem_req}, 32'h0);
         check("stall_pc", pc, 32'h0000_0028);
         check("stall_ins", ins, 32'hA5A5_0000);
      end
      imem_ack = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      resolve = 1'b0;
      wait_req("after_stall");
      check("after_stall_addr", imem_addr, 32'h0000_002C);

      // imem never acks: fault after exactly Timeout request cycles.
      for (int k = 1; k <= int'(Timeout); k++) begin
         @(negedge clk);
         if (k < int'(Timeout)) begin
            check("to_fault_early", {31'h0, fault}, 32'h0);
         end else begin
            check("to_fault", {31'h0, fault}, 32'h1);
            check("to_req_low", {31'h0, imem_req}, 32'h0);
            check("to_valid_low", {31'h0, ins_valid}, 32'h0);
         end
      end
      imem_ack = 1'b1;
      repeat (2) @(negedge clk);
      imem_ack = 1'b0;
      check("fault_sticky", {31'h0, fault}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("fault_rst_fault", {31'h0, fault}, 32'h0);
      check("fault_rst_pc", pc, 32'h0);
      check("fault_rst_epc", epc, 32'h0);
      check("fault_rst_req", {31'h0, imem_req}, 32'h0);
      rst = 1'b0;

      // Reset arriving with an in-flight ack discards the ack.
      wait_req("midrst");
      imem_ack = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      rst = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check("midrst_req", {31'h0, imem_req}, 32'h0);
      check("midrst_valid", {31'h0, ins_valid}, 32'h0);
      check("midrst_ins", ins, 32'h0);
      rst = 1'b0;
      wait_req("post_rst");
      check("post_rst_addr", imem_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
